// File: rtl/mem_arbiter.sv
// Byte-serial RAM/IO bus sequencer shared by the icache and the load/store buffer.
// Requests are split into byte beats; reads absorb the one-cycle RAM latency.
module mem_arbiter #(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              clear,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [31:0]       ic_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_len,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        beats;
    logic              last_ls;
    logic              wr_op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    logic [ADDR_W-1:0] beat_a;
    logic              beat_rd;
    logic              beat_wr;
    logic              stall;
    logic              pick_ls;
    logic              done_ok;
    logic [1:0]        cap_idx;
    logic [2:0]        ls_beats;

    always_comb begin
        beat_a  = addr + ADDR_W'(cnt);
        beat_rd = (state == RD) && (cnt != beats);
        beat_wr = (state == WR);
        stall   = beat_wr && io_buffer_full &&
                  (beat_a[17:16] == IO_BASE[17:16]);
        pick_ls = ls_req && (!ic_req || !last_ls);
        cap_idx = 2'(cnt - 3'd1);
        done_ok = (state == DONE) && ready && !(clear && !wr_op);
        unique case (ls_len)
            2'd0:    ls_beats = 3'd1;
            2'd1:    ls_beats = 3'd2;
            default: ls_beats = 3'd4;
        endcase
    end

    assign mem_a    = (beat_rd || beat_wr) ? beat_a : '0;
    assign mem_wr   = beat_wr && ready && !stall;
    assign mem_dout = beat_wr ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;
    assign ic_done  = done_ok && !last_ls;
    assign ls_done  = done_ok && last_ls;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            beats    <= 3'd0;
            last_ls  <= 1'b0;
            wr_op    <= 1'b0;
            addr     <= '0;
            wdata    <= 32'd0;
            ic_data  <= 32'd0;
            ls_rdata <= 32'd0;
        end else if (ready) begin
            unique case (state)
                IDLE: begin
                    if (!clear && (ic_req || ls_req)) begin
                        last_ls <= pick_ls;
                        cnt     <= 3'd0;
                        if (pick_ls) begin
                            addr  <= ls_addr;
                            wdata <= ls_wdata;
                            wr_op <= ls_wr;
                            beats <= ls_beats;
                            state <= ls_wr ? WR : RD;
                            if (!ls_wr) ls_rdata <= 32'd0;
                        end else begin
                            addr    <= ic_addr;
                            wr_op   <= 1'b0;
                            beats   <= 3'd4;
                            state   <= RD;
                            ic_data <= 32'd0;
                        end
                    end
                end
                RD: begin
                    if (clear) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        // byte for beat cnt-1 arrives one cycle after its address
                        if (cnt != 3'd0) begin
                            if (last_ls)
                                ls_rdata[{cap_idx, 3'b000} +: 8] <= mem_din;
                            else
                                ic_data[{cap_idx, 3'b000} +: 8] <= mem_din;
                        end
                        if (cnt == beats) begin
                            state <= DONE;
                            cnt   <= 3'd0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                WR: begin
                    if (!stall) begin
                        if (cnt == beats - 3'd1) begin
                            state <= DONE;
                            cnt   <= 3'd0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the byte-wide, single-port RAM/IO bus between two requesters.
- The instruction cache issues 4-byte fetch reads.
- The load/store buffer issues 1/2/4-byte loads and committed stores.
- Serialises each request into byte beats and absorbs the 1-cycle RAM read latency. Stalls IO writes while the UART buffer is full. Drops speculative work on pipeline clear.

Parameters:
ADDR_W, 32, address width of requests and of mem_a
IO_BASE, 32'h30000, IO region selector; an address is IO when addr[17:16]==2'b11

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ready  in  1  global enable; low freezes all state
clear  in  1  one-cycle misprediction flush
ic_req  in  1  icache fetch request, held until ic_done
ic_addr  in  ADDR_W  fetch address
ic_done  out  1  one-cycle pulse, ic_data valid
ic_data  out  32  fetched instruction, little-endian
ls_req  in  1  LSB request, held until ls_done
ls_wr  in  1  1 = store, 0 = load
ls_len  in  2  0 byte, 1 half, 2/3 word
ls_addr  in  ADDR_W  access address
ls_wdata  in  32  store data; low bytes used
ls_done  out  1  one-cycle pulse on completion
ls_rdata  out  32  load data, zero-extended
mem_din  in  8  RAM read byte, valid the cycle after its address
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM address
mem_wr  out  1  1 = write this cycle
io_buffer_full  in  1  UART transmit buffer full

Behaviour:
- Reset (reset low, asynchronous): state IDLE, beat counter 0, last_grant = ICACHE, all outputs 0.
- States:
  - IDLE: arbitrate.
  - RD: issue N address beats, then one capture cycle.
  - WR: issue N write beats.
  - DONE: pulse done, no acceptance.
- DONE always returns to IDLE next cycle.
- Arbitration in IDLE, sampled at the clock edge:
  - Only one requester high: grant it.
  - Both high: grant the one not in last_grant (round-robin). After reset the LSB wins the first tie.
  - last_grant updates on every grant.
  - Requests seen in DONE are ignored; a requester must deassert in its done cycle.
- Beat count N: icache is 4; LSB is 1/2/4 from ls_len. Address and data are latched at grant; inputs are don't-care afterwards.
- Read, with grant at edge ending cycle c0:
  - Cycles c1..cN: mem_a = addr+k-1, mem_wr = 0.
  - The mem_din byte in cycle c(k+1) is written to data byte k-1.
  - Capture completes at end of c(N+1).
  - done = 1 in c(N+2), the DONE state. Data is held stable until the next grant to that requester.
  - Latency from grant edge to done: word read 6 cycles, byte read 3 cycles.
- Write:
  - Cycles c1..cN: mem_wr = 1, mem_a = addr+k-1, mem_dout = wdata[8k-1:8k-8].
  - ls_done = 1 in c(N+1).
- IO stall: in WR, if the beat address is IO and io_buffer_full = 1, drive mem_wr = 0 and hold the counter and address. Resume when it drops. Reads are never stalled.
- Outside active beats: mem_wr = 0, mem_a = 0, mem_dout = 0. Done outputs are 0 except in DONE.
- ready = 0: no state, counter or register updates. mem_wr is forced to 0. Beats resume unchanged when ready returns.
- clear = 1 (with ready = 1):
  - Any RD in progress (fetch or load) aborts; the next state is IDLE with no done pulse.
  - A WR in progress continues to completion and its done pulse is emitted, since stores are committed.
  - Requests in the clear cycle are not granted.
  - clear in DONE suppresses the done pulse only for a read.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W. No alignment check; unaligned accesses are serialised byte by byte.

Test Plan:
- ic_req with addr 0x100, RAM bytes 13 05 00 00 -> mem_a 0x100..0x103 in c1..c4; ic_done in c6; ic_data = 0x00000513.
- ic_req and ls_req (load word at 0x200) high together from reset -> LSB served first; icache granted the cycle after the LSB DONE; no bus overlap.
- Store half 0xBEEF to 0x1000 -> c1: mem_wr = 1, a = 0x1000, dout = 0xEF; c2: a = 0x1001, dout = 0xBE; ls_done in c3.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write beat; ls_done the next cycle.
- clear in c2 of a fetch -> no ic_done, IDLE in c3, a new request is granted normally. clear in c2 of a word store -> all 4 beats still issued and ls_done pulses.
- ready low for 2 cycles mid-load -> mem_wr = 0, beat index frozen; completion is delayed by exactly 2 cycles with correct data.
